load_store_unit: RTL and testbench

- Sits between the core's memory stage and the word-only data RAM; turns byte/half/word load and store requests into RAM word accesses.
- Loads: extracts the addressed lane and sign/zero-extends it.
- Sub-word stores: read-modify-write, because the RAM has no byte enables.
- Misaligned and out-of-range requests are rejected with an error response and no RAM access.

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bridges byte/half/word core requests onto a word-only RAM,
// using read-modify-write for sub-word stores and rejecting bad requests.
module load_store_unit #(
    parameter int unsigned LEN = 4096
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respError,
    output logic        memEnable,
    output logic        memWriteEnable,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] MERGE = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [32:0] ADDR_LIMIT = 33'(LEN) * 33'd4;

    logic [1:0]  state, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic [31:0] data_q;

    logic        req_err_c;
    logic [4:0]  sh_c;
    logic [31:0] shifted_c;
    logic [31:0] load_val_c;
    logic [31:0] lane_mask_c;
    logic [31:0] merged_c;
    logic        resp_valid_d;
    logic        resp_error_d;
    logic [31:0] resp_data_d;

    assign reqReady = (state == IDLE);

    // Request legality: bad size, misalignment, or beyond the end of RAM
    always_comb begin
        req_err_c = ({1'b0, reqAddress} >= ADDR_LIMIT);
        case (reqSize)
            SZ_HALF: req_err_c = req_err_c | reqAddress[0];
            SZ_WORD: req_err_c = req_err_c | (|reqAddress[1:0]);
            SZ_BYTE: req_err_c = req_err_c;
            default: req_err_c = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    assign sh_c      = {addr_q[1:0], 3'b000};
    assign shifted_c = memReadData >> sh_c;

    always_comb begin
        load_val_c  = shifted_c;
        lane_mask_c = 32'h0000_00FF;
        case (size_q)
            SZ_BYTE: load_val_c = uns_q ? {24'h0, shifted_c[7:0]}
                                        : {{24{shifted_c[7]}}, shifted_c[7:0]};
            SZ_HALF: begin
                load_val_c  = uns_q ? {16'h0, shifted_c[15:0]}
                                    : {{16{shifted_c[15]}}, shifted_c[15:0]};
                lane_mask_c = 32'h0000_FFFF;
            end
            default: load_val_c = shifted_c;
        endcase
        merged_c = (memReadData & ~(lane_mask_c << sh_c)) | ((data_q & lane_mask_c) << sh_c);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d      = state;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_data_d  = 32'h0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (req_err_c) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (reqWrite && (reqSize == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:  state_d = MERGE;
            MERGE: begin
                if (write_q) begin
                    state_d = WRITE;
                end else begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_val_c;
                end
            end
            WRITE: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch; data_q later holds the merged word for sub-word stores
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            data_q  <= 32'h0;
        end else if (reqValid && reqReady) begin
            addr_q  <= reqAddress;
            size_q  <= reqSize;
            uns_q   <= reqUnsigned;
            write_q <= reqWrite;
            data_q  <= reqData;
        end else if ((state == MERGE) && write_q) begin
            data_q  <= merged_c;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            respValid <= 1'b0;
            respError <= 1'b0;
            respData  <= 32'h0;
        end else begin
            respValid <= resp_valid_d;
            respError <= resp_error_d;
            respData  <= resp_data_d;
        end
    end

    assign memEnable      = (state != IDLE);
    assign memWriteEnable = (state == WRITE);
    assign memAddress     = {addr_q[31:2], 2'b00};
    assign memWriteData   = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word RAM.
module tb_load_store_unit;

    logic        clk;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddress;
    logic [31:0] reqData;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic        memEnable;
    logic        memWriteEnable;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram [0:4095];
    int          wr_count = 0;
    int          en_count = 0;
    int          resp_count = 0;
    logic [31:0] last_waddr = 32'h0;

    load_store_unit #(.LEN(4096)) dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddress(reqAddress),
        .reqData(reqData), .respValid(respValid), .respData(respData),
        .respError(respError), .memEnable(memEnable), .memWriteEnable(memWriteEnable),
        .memAddress(memAddress), .memWriteData(memWriteData), .memReadData(memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: synchronous read, data valid the cycle after the enable edge
    always @(posedge clk) begin
        if (memEnable) begin
            en_count = en_count + 1;
            if (memWriteEnable) begin
                ram[memAddress[13:2]] = memWriteData;
                wr_count   = wr_count + 1;
                last_waddr = memAddress;
            end else begin
                memReadData <= ram[memAddress[13:2]];
            end
        end
        if (respValid) resp_count = resp_count + 1;
    end

    // Drive one request from a negedge; returns at the negedge after acceptance
    task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data);
        reqValid    = 1'b1;
        reqWrite    = wr;
        reqSize     = sz;
        reqUnsigned = uns;
        reqAddress  = addr;
        reqData     = data;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    // Cycles from the accept cycle to respValid; 0 when the bound expires
    task automatic wait_resp(output int lat, output logic [31:0] data, output logic err);
        lat = 1;
        while (respValid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat = lat + 1;
        end
        if (respValid !== 1'b1) lat = 0;
        data = respData;
        err  = respError;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddress = 32'h0; reqData = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", reqReady); end
        n_cmp++; if (respValid !== 1'b0) begin n_err++; $display("FAIL reset_respValid got %b want 0", respValid); end
        n_cmp++; if (respError !== 1'b0) begin n_err++; $display("FAIL reset_respError got %b want 0", respError); end
        n_cmp++; if (respData !== 32'h0) begin n_err++; $display("FAIL reset_respData got %h want 0", respData); end
        n_cmp++; if (memEnable !== 1'b0 || memWriteEnable !== 1'b0) begin
            n_err++; $display("FAIL reset_mem got en=%b we=%b want 0 0", memEnable, memWriteEnable);
        end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store_load;
        int lat; logic [31:0] d; logic e; int w0;
        w0 = wr_count;
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        wait_resp(lat, d, e);
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL wstore_latency got %0d want 2", lat); end
        n_cmp++; if (e !== 1'b0 || d !== 32'h0) begin n_err++; $display("FAIL wstore_resp got err=%b data=%h want 0 0", e, d); end
        @(negedge clk);
        n_cmp++; if (respValid !== 1'b0) begin n_err++; $display("FAIL wstore_pulse got %b want 0", respValid); end
        n_cmp++; if (wr_count - w0 != 1 || last_waddr !== 32'h100) begin
            n_err++; $display("FAIL wstore_writes got %0d@%h want 1@00000100", wr_count - w0, last_waddr);
        end
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        wait_resp(lat, d, e);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL wload_latency got %0d want 3", lat); end
        n_cmp++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            n_err++; $display("FAIL wload_data got %h err=%b want deadbeef 0", d, e);
        end
        @(negedge clk);
    endtask

    task automatic test_byte_store;
        int lat; logic [31:0] d; logic e; int w0;
        w0 = wr_count;
        send(1'b1, 2'b00, 1'b0, 32'h101, 32'hAAAABB55);
        wait_resp(lat, d, e);
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL bstore_latency got %0d want 4", lat); end
        n_cmp++; if (wr_count - w0 != 1 || last_waddr !== 32'h100) begin
            n_err++; $display("FAIL bstore_writes got %0d@%h want 1@00000100", wr_count - w0, last_waddr);
        end
        @(negedge clk);
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        wait_resp(lat, d, e);
        n_cmp++; if (d !== 32'hDEAD55EF) begin n_err++; $display("FAIL bstore_merge got %h want dead55ef", d); end
        @(negedge clk);
    endtask

    task automatic test_extension;
        logic [31:0] addr [6];
        logic [1:0]  sz   [6];
        logic        uns  [6];
        logic [31:0] exp  [6];
        int lat; logic [31:0] d; logic e;
        ram[32'h200 >> 2] = 32'h80017F80;
        addr[0] = 32'h200; sz[0] = 2'b00; uns[0] = 1'b0; exp[0] = 32'hFFFFFF80;
        addr[1] = 32'h200; sz[1] = 2'b00; uns[1] = 1'b1; exp[1] = 32'h00000080;
        addr[2] = 32'h201; sz[2] = 2'b00; uns[2] = 1'b0; exp[2] = 32'h0000007F;
        addr[3] = 32'h202; sz[3] = 2'b01; uns[3] = 1'b0; exp[3] = 32'hFFFF8001;
        addr[4] = 32'h202; sz[4] = 2'b01; uns[4] = 1'b1; exp[4] = 32'h00008001;
        addr[5] = 32'h203; sz[5] = 2'b00; uns[5] = 1'b0; exp[5] = 32'hFFFFFF80;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, sz[i], uns[i], addr[i], 32'h0);
            wait_resp(lat, d, e);
            n_cmp++; if (lat != 3 || d !== exp[i] || e !== 1'b0) begin
                n_err++; $display("FAIL ext_%0d got lat=%0d data=%h err=%b want 3 %h 0", i, lat, d, e, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_errors;
        logic [31:0] addr [4];
        logic [1:0]  sz   [4];
        int lat; logic [31:0] d; logic e; int en0;
        addr[0] = 32'h101;  sz[0] = 2'b01;
        addr[1] = 32'h102;  sz[1] = 2'b10;
        addr[2] = 32'h100;  sz[2] = 2'b11;
        addr[3] = 32'h4000; sz[3] = 2'b10;
        en0 = en_count;
        for (int i = 0; i < 4; i++) begin
            send(i[0], sz[i], 1'b0, addr[i], 32'hFFFFFFFF);
            n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL err_%0d_ready got %b want 1", i, reqReady); end
            wait_resp(lat, d, e);
            n_cmp++; if (lat != 1 || e !== 1'b1 || d !== 32'h0) begin
                n_err++; $display("FAIL err_%0d got lat=%0d err=%b data=%h want 1 1 0", i, lat, e, d);
            end
            @(negedge clk);
        end
        n_cmp++; if (en_count != en0) begin n_err++; $display("FAIL err_mem_enable got %0d want 0", en_count - en0); end
    endtask

    task automatic test_reset_mid_store;
        int lat; logic [31:0] d; logic e; int w0; int r0;
        ram[32'h104 >> 2] = 32'h11223344;
        w0 = wr_count;
        r0 = resp_count;
        send(1'b1, 2'b00, 1'b0, 32'h104, 32'h000000AB);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        n_cmp++; if (memEnable !== 1'b0 || memWriteEnable !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_mem got en=%b we=%b want 0 0", memEnable, memWriteEnable);
        end
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b want 1", reqReady); end
        n_cmp++; if (wr_count != w0 || resp_count != r0) begin
            n_err++; $display("FAIL rst_mid_side got writes=%0d resps=%0d want 0 0", wr_count - w0, resp_count - r0);
        end
        send(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        wait_resp(lat, d, e);
        n_cmp++; if (d !== 32'h11223344) begin n_err++; $display("FAIL rst_mid_data got %h want 11223344", d); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] d; logic e;
        send(1'b1, 2'b10, 1'b0, 32'h300, 32'h12345678);
        wait_resp(lat, d, e);
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL b2b_store_latency got %0d want 2", lat); end
        n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", reqReady); end
        send(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        wait_resp(lat, d, e);
        n_cmp++; if (lat != 3 || d !== 32'h12345678) begin
            n_err++; $display("FAIL b2b_load got lat=%0d data=%h want 3 12345678", lat, d);
        end
        send(1'b1, 2'b01, 1'b0, 32'h302, 32'hFFFFCAFE);
        wait_resp(lat, d, e);
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL b2b_hstore_latency got %0d want 4", lat); end
        send(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        wait_resp(lat, d, e);
        n_cmp++; if (d !== 32'hCAFE5678) begin n_err++; $display("FAIL b2b_hmerge got %h want cafe5678", d); end
        @(negedge clk);
    endtask

    initial begin
        memReadData = 32'h0;
        test_reset;
        test_word_store_load;
        test_byte_store;
        test_extension;
        test_errors;
        test_reset_mid_store;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
